// File: rtl/wb_ram_port_arbiter.sv
// wb_ram_port_arbiter
// Shares one single-port block RAM (1-cycle registered read, byte-enabled
// write) between two Wishbone slave ports. Arbitration is round-robin between
// s0 and s1. A grant stays locked for an incrementing burst, but only up to
// MAX_BURST beats, so neither master can starve the other.
//
// Ports
//   clk, reset              rising-edge clock, synchronous active-low reset
//   sN_dat_i/sel_i/addr_i   write data, byte selects, word address of port N
//   sN_cti_i/bte_i          Wishbone cycle type and burst type of port N
//   sN_stb_i/cyc_i/we_i     strobe, cycle, write enable of port N
//   sN_dat_o/ack_o          read data (zero unless acking a read), acknowledge
//   sN_err_o/rty_o          always 0
//   ram_d/addr/we/byteen    RAM-side write data, address, write enable, byte enables
//   ram_q                   RAM read data, valid one cycle after ram_addr
module wb_ram_port_arbiter #(
  parameter int Dw        = 32,
  parameter int Aw        = 10,
  parameter int SELw      = Dw / 8,
  parameter int CTIw      = 3,
  parameter int BTEw      = 2,
  parameter int MAX_BURST = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [Dw-1:0]   s0_dat_i,
  input  logic [SELw-1:0] s0_sel_i,
  input  logic [Aw-1:0]   s0_addr_i,
  input  logic [CTIw-1:0] s0_cti_i,
  input  logic [BTEw-1:0] s0_bte_i,
  input  logic            s0_stb_i,
  input  logic            s0_cyc_i,
  input  logic            s0_we_i,
  output logic [Dw-1:0]   s0_dat_o,
  output logic            s0_ack_o,
  output logic            s0_err_o,
  output logic            s0_rty_o,
  input  logic [Dw-1:0]   s1_dat_i,
  input  logic [SELw-1:0] s1_sel_i,
  input  logic [Aw-1:0]   s1_addr_i,
  input  logic [CTIw-1:0] s1_cti_i,
  input  logic [BTEw-1:0] s1_bte_i,
  input  logic            s1_stb_i,
  input  logic            s1_cyc_i,
  input  logic            s1_we_i,
  output logic [Dw-1:0]   s1_dat_o,
  output logic            s1_ack_o,
  output logic            s1_err_o,
  output logic            s1_rty_o,
  output logic [Dw-1:0]   ram_d,
  output logic [Aw-1:0]   ram_addr,
  output logic            ram_we,
  output logic [SELw-1:0] ram_byteen,
  input  logic [Dw-1:0]   ram_q
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_XFER = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            g_q, g_d;
  logic            last_g_q, last_g_d;
  logic [Aw-1:0]   beat_addr_q, beat_addr_d;
  logic [7:0]      beat_cnt_q, beat_cnt_d;

  logic            req0_s, req1_s, pick_s;
  logic            sg_cyc_s, sg_stb_s, sg_we_s;
  logic [Dw-1:0]   sg_dat_s;
  logic [SELw-1:0] sg_sel_s;
  logic [CTIw-1:0] sg_cti_s;
  logic [BTEw-1:0] sg_bte_s;
  logic [Aw-1:0]   nxt_addr_s;
  logic [8:0]      beat_cnt_inc_s;
  logic            ack_s, cont_s;
  logic [Dw-1:0]   rdata_s;

  // Next beat address. Linear bursts wrap the whole word space; wrap bursts
  // only advance the low 2/3/4 bits and hold the upper bits.
  function automatic logic [Aw-1:0] next_beat_addr(input logic [Aw-1:0]   a,
                                                   input logic [BTEw-1:0] bte);
    logic [Aw-1:0] inc;
    logic [Aw-1:0] mask;
    inc = a + {{(Aw-1){1'b0}}, 1'b1};
    case (bte[1:0])
      2'b01:   mask = {{(Aw-2){1'b0}}, 2'b11};
      2'b10:   mask = {{(Aw-3){1'b0}}, 3'b111};
      2'b11:   mask = {{(Aw-4){1'b0}}, 4'b1111};
      default: mask = {Aw{1'b1}};
    endcase
    return (a & ~mask) | (inc & mask);
  endfunction

  assign req0_s = s0_cyc_i & s0_stb_i;
  assign req1_s = s1_cyc_i & s1_stb_i;
  // With both requesting, the port that did not win last time gets the grant.
  assign pick_s = (req0_s & req1_s) ? ~last_g_q : req1_s;

  assign sg_cyc_s = g_q ? s1_cyc_i : s0_cyc_i;
  assign sg_stb_s = g_q ? s1_stb_i : s0_stb_i;
  assign sg_we_s  = g_q ? s1_we_i  : s0_we_i;
  assign sg_dat_s = g_q ? s1_dat_i : s0_dat_i;
  assign sg_sel_s = g_q ? s1_sel_i : s0_sel_i;
  assign sg_cti_s = g_q ? s1_cti_i : s0_cti_i;
  assign sg_bte_s = g_q ? s1_bte_i : s0_bte_i;

  assign nxt_addr_s     = next_beat_addr(beat_addr_q, sg_bte_s);
  assign beat_cnt_inc_s = {1'b0, beat_cnt_q} + 9'd1;
  assign ack_s          = (state_q == ST_XFER) & sg_cyc_s & sg_stb_s;
  assign cont_s         = ack_s & (sg_cti_s == 3'b010) & (beat_cnt_inc_s < 9'(MAX_BURST));
  assign rdata_s        = (ack_s & ~sg_we_s) ? ram_q : {Dw{1'b0}};

  // State, grant and burst bookkeeping registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      g_q         <= 1'b0;
      last_g_q    <= 1'b1;
      beat_addr_q <= {Aw{1'b0}};
      beat_cnt_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      g_q         <= g_d;
      last_g_q    <= last_g_d;
      beat_addr_q <= beat_addr_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

  // Next-state logic: arbitrate in IDLE, address phase in WAIT, beats in XFER.
  always_comb begin
    state_d     = state_q;
    g_d         = g_q;
    last_g_d    = last_g_q;
    beat_addr_d = beat_addr_q;
    beat_cnt_d  = beat_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req0_s | req1_s) begin
          g_d         = pick_s;
          last_g_d    = pick_s;
          beat_addr_d = pick_s ? s1_addr_i : s0_addr_i;
          beat_cnt_d  = 8'd0;
          state_d     = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (sg_cyc_s) begin
          state_d = ST_XFER;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_XFER: begin
        if (cont_s) begin
          beat_cnt_d  = beat_cnt_inc_s[7:0];
          beat_addr_d = nxt_addr_s;
          state_d     = ST_XFER;
        end else begin
          // Classic/end-of-burst, strobe or cycle dropped, or burst cap hit:
          // release the RAM and re-arbitrate.
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // RAM-side and Wishbone-side outputs, decoded from the current state.
  always_comb begin
    ram_addr   = {Aw{1'b0}};
    ram_we     = 1'b0;
    ram_d      = {Dw{1'b0}};
    ram_byteen = {SELw{1'b0}};
    case (state_q)
      ST_IDLE: begin
        ram_addr = {Aw{1'b0}};
      end
      ST_WAIT: begin
        ram_addr = beat_addr_q;
      end
      ST_XFER: begin
        // A continuing read presents the next address now so that its data
        // lands in the next cycle and acks stay back-to-back.
        if (cont_s && !sg_we_s) begin
          ram_addr = nxt_addr_s;
        end else begin
          ram_addr = beat_addr_q;
        end
        if (ack_s && sg_we_s) begin
          ram_we     = 1'b1;
          ram_d      = sg_dat_s;
          ram_byteen = sg_sel_s;
        end else begin
          ram_we     = 1'b0;
          ram_d      = {Dw{1'b0}};
          ram_byteen = {SELw{1'b0}};
        end
      end
      default: begin
        ram_addr = {Aw{1'b0}};
      end
    endcase
    s0_ack_o = ack_s & ~g_q;
    s1_ack_o = ack_s & g_q;
    s0_dat_o = g_q ? {Dw{1'b0}} : rdata_s;
    s1_dat_o = g_q ? rdata_s : {Dw{1'b0}};
    s0_err_o = 1'b0;
    s0_rty_o = 1'b0;
    s1_err_o = 1'b0;
    s1_rty_o = 1'b0;
  end

endmodule

// File: tb/tb_wb_ram_port_arbiter.sv
// Bench for wb_ram_port_arbiter: two Wishbone master tasks, a behavioural
// block RAM, and a word-level memory model that every acknowledged beat is
// checked against.
module tb_wb_ram_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] s_dat  [2];
  logic [3:0]  s_sel  [2];
  logic [9:0]  s_addr [2];
  logic [2:0]  s_cti  [2];
  logic [1:0]  s_bte  [2];
  logic        s_stb  [2];
  logic        s_cyc  [2];
  logic        s_we   [2];
  logic [31:0] s_dato [2];
  logic        s_ack  [2];
  logic        s_err  [2];
  logic        s_rty  [2];
  logic [31:0] ram_d;
  logic [9:0]  ram_addr;
  logic        ram_we;
  logic [3:0]  ram_byteen;
  logic [31:0] ram_q;

  logic [31:0] ram_mem   [1024];
  logic [31:0] model_mem [1024];
  logic [9:0]  addr_log  [4096];
  logic        pre_we;
  logic [9:0]  pre_addr;
  logic [31:0] pre_dat;
  logic        chk_en = 1'b0;
  int          cyc_cnt = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  int          ack_cyc0[$], ack_cyc1[$];
  logic [31:0] rd0[$], rd1[$];
  int          st, st0, st1;
  logic        ok;

  wb_ram_port_arbiter dut (
    .clk(clk), .reset(reset),
    .s0_dat_i(s_dat[0]), .s0_sel_i(s_sel[0]), .s0_addr_i(s_addr[0]),
    .s0_cti_i(s_cti[0]), .s0_bte_i(s_bte[0]), .s0_stb_i(s_stb[0]),
    .s0_cyc_i(s_cyc[0]), .s0_we_i(s_we[0]), .s0_dat_o(s_dato[0]),
    .s0_ack_o(s_ack[0]), .s0_err_o(s_err[0]), .s0_rty_o(s_rty[0]),
    .s1_dat_i(s_dat[1]), .s1_sel_i(s_sel[1]), .s1_addr_i(s_addr[1]),
    .s1_cti_i(s_cti[1]), .s1_bte_i(s_bte[1]), .s1_stb_i(s_stb[1]),
    .s1_cyc_i(s_cyc[1]), .s1_we_i(s_we[1]), .s1_dat_o(s_dato[1]),
    .s1_ack_o(s_ack[1]), .s1_err_o(s_err[1]), .s1_rty_o(s_rty[1]),
    .ram_d(ram_d), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_byteen(ram_byteen), .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  // Free-running cycle counter used to time-stamp acks and RAM addresses.
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Behavioural block RAM: byte-enabled write, registered read (old data).
  always @(posedge clk) begin
    if (pre_we) begin
      ram_mem[pre_addr] <= pre_dat;
    end else if (ram_we) begin
      for (int b = 0; b < 4; b++)
        if (ram_byteen[b]) ram_mem[ram_addr][8*b +: 8] <= ram_d[8*b +: 8];
    end
    ram_q <= ram_mem[ram_addr];
  end

  function automatic logic [31:0] init_word(input int i);
    case (i)
      5:       return 32'hDEADBEEF;
      32:      return 32'h00000000;
      0:       return 32'hC0FFEE00;
      default: return 32'h5A000000 | (32'(i) * 32'h00010003);
    endcase
  endfunction

  // Wrap-burst address rule written as plain arithmetic on the burst length.
  function automatic logic [9:0] next_addr(input logic [9:0] a, input logic [1:0] bte);
    int len;
    int base;
    if (bte == 2'b00) return 10'((int'(a) + 1) % 1024);
    len  = 2 << bte;
    base = int'(a) - (int'(a) % len);
    return 10'(base + ((int'(a) % len) + 1) % len);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk = n_chk + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Wishbone master: n beats from a0 (classic if n==1), holds each beat until acked.
  task automatic wb_xfer(input int p, input logic [9:0] a0, input int n, input logic we,
                         input logic [1:0] bte, input logic [31:0] d0, input logic [3:0] sel,
                         output int start);
    logic [9:0] a;
    int to;
    a = a0;
    start = cyc_cnt;
    for (int b = 0; b < n; b++) begin
      s_cyc[p] = 1'b1; s_stb[p] = 1'b1; s_we[p] = we; s_addr[p] = a;
      s_dat[p] = d0 + 32'(b); s_sel[p] = sel; s_bte[p] = bte;
      s_cti[p] = (n == 1) ? 3'b000 : ((b == n - 1) ? 3'b111 : 3'b010);
      to = 0;
      forever begin
        @(negedge clk);
        if (s_ack[p]) break;
        to++;
        if (to > 64) begin
          chk("ack_timeout", 64'd0, 64'd1);
          s_cyc[p] = 1'b0; s_stb[p] = 1'b0; s_we[p] = 1'b0; s_cti[p] = 3'b000;
          return;
        end
        @(posedge clk); #1;
      end
      @(posedge clk); #1;
      a = next_addr(a, bte);
    end
    s_cyc[p] = 1'b0; s_stb[p] = 1'b0; s_we[p] = 1'b0; s_cti[p] = 3'b000;
  endtask

  // Compare process: every cycle, check DUT outputs against the memory model.
  always @(negedge clk) begin
    if (pre_we) model_mem[pre_addr] <= pre_dat;
    addr_log[cyc_cnt % 4096] <= ram_addr;
    if (chk_en) begin
      chk("ack_exclusive", 64'(s_ack[0] & s_ack[1]), 64'd0);
      for (int p = 0; p < 2; p++) begin
        chk("err_rty_zero", 64'({s_err[p], s_rty[p]}), 64'd0);
        if (s_ack[p]) begin
          chk("ack_needs_req", 64'(s_cyc[p] & s_stb[p]), 64'd1);
          if (p == 0) ack_cyc0.push_back(cyc_cnt); else ack_cyc1.push_back(cyc_cnt);
          if (s_we[p]) begin
            chk("wr_we", 64'(ram_we), 64'd1);
            chk("wr_addr", 64'(ram_addr), 64'(s_addr[p]));
            chk("wr_data", 64'(ram_d), 64'(s_dat[p]));
            chk("wr_byteen", 64'(ram_byteen), 64'(s_sel[p]));
            for (int b = 0; b < 4; b++)
              if (s_sel[p][b]) model_mem[s_addr[p]][8*b +: 8] <= s_dat[p][8*b +: 8];
          end else begin
            chk("rd_data", 64'(s_dato[p]), 64'(model_mem[s_addr[p]]));
            chk("rd_no_we", 64'(ram_we), 64'd0);
            if (p == 0) rd0.push_back(s_dato[p]); else rd1.push_back(s_dato[p]);
          end
        end else begin
          chk("dat_masked", 64'(s_dato[p]), 64'd0);
        end
      end
      if (!s_ack[0] && !s_ack[1]) chk("no_ack_no_we", 64'(ram_we), 64'd0);
    end
  end

  task automatic clear_logs();
    ack_cyc0.delete(); ack_cyc1.delete(); rd0.delete(); rd1.delete();
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; pre_we = 1'b0; pre_addr = 10'd0; pre_dat = 32'd0;
    for (int p = 0; p < 2; p++) begin
      s_dat[p] = 32'd0; s_sel[p] = 4'd0; s_addr[p] = 10'd0; s_cti[p] = 3'd0;
      s_bte[p] = 2'd0; s_stb[p] = 1'b0; s_cyc[p] = 1'b0; s_we[p] = 1'b0;
    end
    @(posedge clk); #1;
    for (int i = 0; i < 1024; i++) begin
      pre_we = 1'b1; pre_addr = 10'(i); pre_dat = init_word(i);
      @(posedge clk); #1;
    end
    pre_we = 1'b0;
    @(posedge clk); #1;
    // Reset state, still in reset.
    @(negedge clk);
    chk("rst_ack0", 64'(s_ack[0]), 64'd0);
    chk("rst_ack1", 64'(s_ack[1]), 64'd0);
    chk("rst_dat0", 64'(s_dato[0]), 64'd0);
    chk("rst_dat1", 64'(s_dato[1]), 64'd0);
    chk("rst_ram_we", 64'(ram_we), 64'd0);
    chk("rst_ram_addr", 64'(ram_addr), 64'd0);
    chk("rst_ram_byteen", 64'(ram_byteen), 64'd0);
    chk("rst_ram_d", 64'(ram_d), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    chk_en = 1'b1;

    // Simultaneous writes straight out of reset: s0 first, s1 three cycles later.
    clear_logs();
    fork
      wb_xfer(0, 10'h010, 1, 1'b1, 2'b00, 32'h11111111, 4'hF, st0);
      wb_xfer(1, 10'h011, 1, 1'b1, 2'b00, 32'h22222222, 4'hF, st1);
    join
    settle();
    chk("tie_s0_count", ack_cyc0.size(), 1);
    chk("tie_s1_count", ack_cyc1.size(), 1);
    if (ack_cyc0.size() == 1 && ack_cyc1.size() == 1) begin
      chk("tie_s0_latency", ack_cyc0[0] - st0, 2);
      chk("tie_s1_after_s0", ack_cyc1[0] - ack_cyc0[0], 3);
    end
    clear_logs();
    wb_xfer(0, 10'h010, 1, 1'b0, 2'b00, 32'd0, 4'hF, st);
    wb_xfer(1, 10'h011, 1, 1'b0, 2'b00, 32'd0, 4'hF, st);
    settle();
    if (rd0.size() == 1 && rd1.size() == 1) begin
      chk("readback_s0", rd0[0], 32'h11111111);
      chk("readback_s1", rd1[0], 32'h22222222);
    end else chk("readback_count", rd0.size() + rd1.size(), 2);

    // Single read: one ack on the third cycle, s1 silent.
    clear_logs();
    wb_xfer(0, 10'h005, 1, 1'b0, 2'b00, 32'd0, 4'hF, st);
    settle();
    chk("single_ack_count", ack_cyc0.size(), 1);
    chk("single_s1_quiet", ack_cyc1.size(), 0);
    if (ack_cyc0.size() == 1) begin
      chk("single_latency", ack_cyc0[0] - st, 2);
      chk("single_data", rd0[0], 32'hDEADBEEF);
    end

    // Wrap4 read burst from 0x00E.
    clear_logs();
    wb_xfer(0, 10'h00E, 4, 1'b0, 2'b01, 32'd0, 4'hF, st);
    settle();
    chk("wrap4_addr0", addr_log[(st + 1) % 4096], 10'h00E);
    chk("wrap4_addr1", addr_log[(st + 2) % 4096], 10'h00F);
    chk("wrap4_addr2", addr_log[(st + 3) % 4096], 10'h00C);
    chk("wrap4_addr3", addr_log[(st + 4) % 4096], 10'h00D);
    chk("wrap4_acks", ack_cyc0.size(), 4);
    if (ack_cyc0.size() == 4) begin
      ok = 1'b1;
      for (int i = 0; i < 4; i++) if (ack_cyc0[i] != st + 2 + i) ok = 1'b0;
      chk("wrap4_back_to_back", 64'(ok), 64'd1);
    end

    // Burst cap: 20-beat linear s0 burst, s1 arrives mid-burst.
    clear_logs();
    fork
      wb_xfer(0, 10'h100, 20, 1'b0, 2'b00, 32'd0, 4'hF, st0);
      begin
        repeat (5) @(posedge clk);
        #1;
        wb_xfer(1, 10'h200, 1, 1'b0, 2'b00, 32'd0, 4'hF, st1);
      end
    join
    settle();
    chk("cap_s0_beats", ack_cyc0.size(), 20);
    chk("cap_s1_beats", ack_cyc1.size(), 1);
    if (ack_cyc0.size() == 20 && ack_cyc1.size() == 1) begin
      ok = 1'b1;
      for (int i = 1; i < 16; i++) if (ack_cyc0[i] != ack_cyc0[i - 1] + 1) ok = 1'b0;
      chk("cap_16_back_to_back", 64'(ok), 64'd1);
      chk("cap_s1_slot", ack_cyc1[0] - ack_cyc0[15], 3);
      chk("cap_s0_resume_slot", ack_cyc0[16] - ack_cyc1[0], 3);
      chk("cap_resume_addr", addr_log[(ack_cyc0[16] - 1) % 4096], 10'h110);
      chk("cap_resume_data", rd0[16], init_word(32'h110));
    end

    // Byte-lane write into a zero word, then a linear burst across the top.
    clear_logs();
    wb_xfer(0, 10'h020, 1, 1'b1, 2'b00, 32'hAABBCCDD, 4'b0010, st);
    wb_xfer(0, 10'h020, 1, 1'b0, 2'b00, 32'd0, 4'hF, st);
    settle();
    if (rd0.size() == 1) chk("byte_lane_readback", rd0[0], 32'h0000CC00);
    else chk("byte_lane_count", rd0.size(), 1);
    clear_logs();
    wb_xfer(0, 10'h3FF, 3, 1'b0, 2'b00, 32'd0, 4'hF, st);
    settle();
    chk("top_wrap_addr0", addr_log[(st + 1) % 4096], 10'h3FF);
    chk("top_wrap_addr1", addr_log[(st + 2) % 4096], 10'h000);
    if (rd0.size() == 3) chk("top_wrap_data1", rd0[1], 32'hC0FFEE00);
    else chk("top_wrap_count", rd0.size(), 3);

    // Wrap8 write burst from 0x05E lands on 5E,5F,58,59.
    clear_logs();
    wb_xfer(1, 10'h05E, 4, 1'b1, 2'b10, 32'h70000000, 4'hF, st);
    wb_xfer(0, 10'h058, 1, 1'b0, 2'b00, 32'd0, 4'hF, st);
    settle();
    if (rd0.size() == 1) chk("wrap8_readback", rd0[0], 32'h70000002);
    else chk("wrap8_count", rd0.size(), 1);

    // Reset during the address phase of an s1 write.
    clear_logs();
    s_cyc[1] = 1'b1; s_stb[1] = 1'b1; s_we[1] = 1'b1; s_addr[1] = 10'h030;
    s_dat[1] = 32'h99999999; s_sel[1] = 4'hF; s_cti[1] = 3'b000; s_bte[1] = 2'b00;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_mid_ack1", 64'(s_ack[1]), 64'd0);
      chk("rst_mid_we", 64'(ram_we), 64'd0);
      @(posedge clk); #1;
    end
    s_cyc[1] = 1'b0; s_stb[1] = 1'b0; s_we[1] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    chk("rst_mid_no_acks", ack_cyc1.size(), 0);
    fork
      wb_xfer(0, 10'h040, 1, 1'b0, 2'b00, 32'd0, 4'hF, st0);
      wb_xfer(1, 10'h041, 1, 1'b0, 2'b00, 32'd0, 4'hF, st1);
    join
    settle();
    if (ack_cyc0.size() == 1 && ack_cyc1.size() == 1)
      chk("rst_tie_s0_first", 64'(ack_cyc0[0] < ack_cyc1[0]), 64'd1);
    else chk("rst_tie_counts", ack_cyc0.size() + ack_cyc1.size(), 2);
    clear_logs();
    wb_xfer(0, 10'h030, 1, 1'b0, 2'b00, 32'd0, 4'hF, st);
    settle();
    if (rd0.size() == 1) chk("rst_write_dropped", rd0[0], init_word(32'h030));
    else chk("rst_readback_count", rd0.size(), 1);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
